// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states and
// the byte-lane mask helper.
package mem_stage_pkg;

    localparam int DMEM_MASK_W = 8;

    typedef enum logic [1:0] {
        MEM_SIZE_B = 2'd0,
        MEM_SIZE_H = 2'd1,
        MEM_SIZE_W = 2'd2,
        MEM_SIZE_D = 2'd3
    } mem_size_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    // Unshifted byte enables for an access of the given size.
    function automatic logic [DMEM_MASK_W-1:0] lane_mask(input logic [1:0] size);
        logic [DMEM_MASK_W-1:0] mask;
        case (size)
            MEM_SIZE_B: mask = 8'h01;
            MEM_SIZE_H: mask = 8'h03;
            MEM_SIZE_W: mask = 8'h0F;
            MEM_SIZE_D: mask = 8'hFF;
            default:    mask = 8'h00;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational lane logic: store shift/mask, load extract/extend and
// misalignment detection for one 8-byte aligned data-memory word.
module mem_stage_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]             addr_lo,
    input  logic [1:0]             size,
    input  logic                   is_unsigned,
    input  logic [XLEN-1:0]        store_data,
    input  logic [XLEN-1:0]        rdata,
    output logic [XLEN-1:0]        wdata,
    output logic [DMEM_MASK_W-1:0] wmask,
    output logic [XLEN-1:0]        load_data,
    output logic                   misaligned
);

    logic [XLEN-1:0] shifted_s;
    logic            fill_s;

    // Store lane alignment and load extraction/extension.
    always_comb begin
        wdata     = store_data << {addr_lo, 3'b000};
        wmask     = lane_mask(size) << addr_lo;
        shifted_s = rdata >> {addr_lo, 3'b000};
        fill_s    = 1'b0;
        load_data = shifted_s;
        case (size)
            MEM_SIZE_B: begin
                fill_s    = ~is_unsigned & shifted_s[7];
                load_data = {{(XLEN-8){fill_s}}, shifted_s[7:0]};
            end
            MEM_SIZE_H: begin
                fill_s    = ~is_unsigned & shifted_s[15];
                load_data = {{(XLEN-16){fill_s}}, shifted_s[15:0]};
            end
            MEM_SIZE_W: begin
                fill_s    = ~is_unsigned & shifted_s[31];
                load_data = {{(XLEN-32){fill_s}}, shifted_s[31:0]};
            end
            default: begin
                load_data = shifted_s;
            end
        endcase
    end

    // Natural alignment check for the requested access size.
    always_comb begin
        case (size)
            MEM_SIZE_B: misaligned = 1'b0;
            MEM_SIZE_H: misaligned = addr_lo[0];
            MEM_SIZE_W: misaligned = |addr_lo[1:0];
            MEM_SIZE_D: misaligned = |addr_lo;
            default:    misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU results to write-back or performs one
// load/store over a req/ack data-memory bus, stalling execute meanwhile.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid,
    output logic                   ex_ready,
    input  logic [XLEN-1:0]        ex_rd_data,
    input  logic [XLEN-1:0]        ex_store_data,
    input  logic [4:0]             ex_rd_addr,
    input  logic                   ex_rd_wena,
    input  logic                   ex_mem_ren,
    input  logic                   ex_mem_wen,
    input  logic [1:0]             ex_mem_size,
    input  logic                   ex_mem_unsigned,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [XLEN-1:0]        dmem_addr,
    output logic [XLEN-1:0]        dmem_wdata,
    output logic [DMEM_MASK_W-1:0] dmem_wmask,
    input  logic                   dmem_ack,
    input  logic [XLEN-1:0]        dmem_rdata,
    output logic                   wb_valid,
    output logic [4:0]             wb_rd_addr,
    output logic                   wb_rd_wena,
    output logic [XLEN-1:0]        wb_rd_data,
    output logic                   misalign_err
);

    state_e                 state_r;
    logic [2:0]             addr_lo_r;
    logic [1:0]             size_r;
    logic                   unsigned_r;
    logic [4:0]             rd_addr_r;
    logic                   rd_wena_r;

    logic [2:0]             sel_addr_lo_s;
    logic [1:0]             sel_size_s;
    logic                   mem_op_s;
    logic                   is_store_s;
    logic [XLEN-1:0]        wdata_s;
    logic [DMEM_MASK_W-1:0] wmask_s;
    logic [XLEN-1:0]        load_data_s;
    logic                   misaligned_s;

    // Decode the incoming op; the lane unit sees execute inputs while idle and
    // the latched access attributes while waiting for the ack.
    always_comb begin
        ex_ready   = (state_r == ST_IDLE);
        mem_op_s   = ex_mem_ren | ex_mem_wen;
        is_store_s = ex_mem_wen & ~ex_mem_ren;
        if (state_r == ST_IDLE) begin
            sel_addr_lo_s = ex_rd_data[2:0];
            sel_size_s    = ex_mem_size;
        end else begin
            sel_addr_lo_s = addr_lo_r;
            sel_size_s    = size_r;
        end
    end

    mem_stage_align #(.XLEN(XLEN)) u_align (
        .addr_lo     (sel_addr_lo_s),
        .size        (sel_size_s),
        .is_unsigned (unsigned_r),
        .store_data  (ex_store_data),
        .rdata       (dmem_rdata),
        .wdata       (wdata_s),
        .wmask       (wmask_s),
        .load_data   (load_data_s),
        .misaligned  (misaligned_s)
    );

    // Stage FSM with registered bus and write-back outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            addr_lo_r    <= 3'd0;
            size_r       <= 2'd0;
            unsigned_r   <= 1'b0;
            rd_addr_r    <= 5'd0;
            rd_wena_r    <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_wmask   <= 8'h00;
            wb_valid     <= 1'b0;
            wb_rd_addr   <= 5'd0;
            wb_rd_wena   <= 1'b0;
            wb_rd_data   <= '0;
            misalign_err <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            misalign_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ex_valid && !mem_op_s) begin
                        wb_valid   <= 1'b1;
                        wb_rd_addr <= ex_rd_addr;
                        wb_rd_wena <= ex_rd_wena;
                        wb_rd_data <= ex_rd_data;
                    end else if (ex_valid && misaligned_s) begin
                        wb_valid     <= 1'b1;
                        wb_rd_addr   <= ex_rd_addr;
                        wb_rd_wena   <= 1'b0;
                        wb_rd_data   <= '0;
                        misalign_err <= 1'b1;
                    end else if (ex_valid) begin
                        state_r    <= ST_ACCESS;
                        addr_lo_r  <= ex_rd_data[2:0];
                        size_r     <= ex_mem_size;
                        unsigned_r <= ex_mem_unsigned;
                        rd_addr_r  <= ex_rd_addr;
                        rd_wena_r  <= ex_rd_wena;
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_store_s;
                        dmem_addr  <= {ex_rd_data[XLEN-1:3], 3'b000};
                        dmem_wdata <= is_store_s ? wdata_s : '0;
                        dmem_wmask <= is_store_s ? wmask_s : 8'h00;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ack) begin
                        state_r    <= ST_IDLE;
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        dmem_wmask <= 8'h00;
                        wb_valid   <= 1'b1;
                        wb_rd_addr <= rd_addr_r;
                        wb_rd_wena <= dmem_we ? 1'b0 : rd_wena_r;
                        wb_rd_data <= dmem_we ? '0 : load_data_s;
                    end else begin
                        state_r <= ST_ACCESS;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage with hand-computed expectations.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] ex_rd_data;
    logic [63:0] ex_store_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_wena;
    logic        ex_mem_ren;
    logic        ex_mem_wen;
    logic [1:0]  ex_mem_size;
    logic        ex_mem_unsigned;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wmask;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_wena;
    logic [63:0] wb_rd_data;
    logic        misalign_err;

    int n_vec = 0;
    int n_err = 0;

    mem_stage #(.XLEN(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_valid        (ex_valid),
        .ex_ready        (ex_ready),
        .ex_rd_data      (ex_rd_data),
        .ex_store_data   (ex_store_data),
        .ex_rd_addr      (ex_rd_addr),
        .ex_rd_wena      (ex_rd_wena),
        .ex_mem_ren      (ex_mem_ren),
        .ex_mem_wen      (ex_mem_wen),
        .ex_mem_size     (ex_mem_size),
        .ex_mem_unsigned (ex_mem_unsigned),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_wmask      (dmem_wmask),
        .dmem_ack        (dmem_ack),
        .dmem_rdata      (dmem_rdata),
        .wb_valid        (wb_valid),
        .wb_rd_addr      (wb_rd_addr),
        .wb_rd_wena      (wb_rd_wena),
        .wb_rd_data      (wb_rd_data),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_op(input logic [63:0] addr, input logic [63:0] sdata, input logic [4:0] rd,
                            input logic wena, input logic ren, input logic wen,
                            input logic [1:0] size, input logic uns);
        ex_valid        = 1'b1;
        ex_rd_data      = addr;
        ex_store_data   = sdata;
        ex_rd_addr      = rd;
        ex_rd_wena      = wena;
        ex_mem_ren      = ren;
        ex_mem_wen      = wen;
        ex_mem_size     = size;
        ex_mem_unsigned = uns;
    endtask

    task automatic idle_ex();
        ex_valid   = 1'b0;
        ex_mem_ren = 1'b0;
        ex_mem_wen = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_ex();
        ex_rd_data = 64'd0; ex_store_data = 64'd0; ex_rd_addr = 5'd0;
        ex_rd_wena = 1'b0; ex_mem_size = 2'd0; ex_mem_unsigned = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = 64'd0;
        tick(); tick();
        rst = 1'b1;

        check("rst_req", {63'd0, dmem_req}, 64'd0);
        check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("rst_ready", {63'd0, ex_ready}, 64'd1);
        check("rst_wmask", {56'd0, dmem_wmask}, 64'd0);
        check("rst_wb_data", wb_rd_data, 64'd0);

        // Non-memory stream of three results.
        for (int i = 1; i <= 3; i++) begin
            drive_op(64'(i), 64'd0, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
            tick();
            check("alu_valid", {63'd0, wb_valid}, 64'd1);
            check("alu_data", wb_rd_data, 64'(i));
            check("alu_rd", {59'd0, wb_rd_addr}, 64'd5);
            check("alu_wena", {63'd0, wb_rd_wena}, 64'd1);
            check("alu_noreq", {63'd0, dmem_req}, 64'd0);
        end
        idle_ex();
        tick();
        check("alu_drop", {63'd0, wb_valid}, 64'd0);

        // Signed byte load, ack two cycles after request.
        drive_op(64'h1003, 64'd0, 5'd7, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
        check("lb_ready_pre", {63'd0, ex_ready}, 64'd1);
        tick();
        idle_ex();
        check("lb_req", {63'd0, dmem_req}, 64'd1);
        check("lb_addr", dmem_addr, 64'h1000);
        check("lb_wmask", {56'd0, dmem_wmask}, 64'd0);
        check("lb_we", {63'd0, dmem_we}, 64'd0);
        check("lb_ready1", {63'd0, ex_ready}, 64'd0);
        tick();
        check("lb_ready2", {63'd0, ex_ready}, 64'd0);
        check("lb_hold_req", {63'd0, dmem_req}, 64'd1);
        tick();
        check("lb_ready3", {63'd0, ex_ready}, 64'd0);
        dmem_ack = 1'b1; dmem_rdata = 64'h00000000_80000000;
        tick();
        dmem_ack = 1'b0;
        check("lb_wb_valid", {63'd0, wb_valid}, 64'd1);
        check("lb_data", wb_rd_data, 64'hFFFFFFFF_FFFFFF80);
        check("lb_wena", {63'd0, wb_rd_wena}, 64'd1);
        check("lb_req_low", {63'd0, dmem_req}, 64'd0);
        check("lb_ready_back", {63'd0, ex_ready}, 64'd1);
        tick();
        check("lb_pulse", {63'd0, wb_valid}, 64'd0);

        // Unsigned half load with same-cycle ack.
        drive_op(64'h2006, 64'd0, 5'd8, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1);
        tick();
        idle_ex();
        check("lhu_req", {63'd0, dmem_req}, 64'd1);
        check("lhu_addr", dmem_addr, 64'h2000);
        dmem_ack = 1'b1; dmem_rdata = 64'hBEEF0000_00000000;
        tick();
        dmem_ack = 1'b0;
        check("lhu_wb_valid", {63'd0, wb_valid}, 64'd1);
        check("lhu_data", wb_rd_data, 64'h00000000_0000BEEF);

        // Signed word load from the upper lane.
        drive_op(64'h6004, 64'd0, 5'd9, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
        tick();
        idle_ex();
        dmem_ack = 1'b1; dmem_rdata = 64'h87654321_00000000;
        tick();
        dmem_ack = 1'b0;
        check("lw_data", wb_rd_data, 64'hFFFFFFFF_87654321);

        // Word store to the upper lane.
        drive_op(64'h3004, 64'h11223344, 5'd10, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0);
        tick();
        idle_ex();
        check("sw_req", {63'd0, dmem_req}, 64'd1);
        check("sw_we", {63'd0, dmem_we}, 64'd1);
        check("sw_wmask", {56'd0, dmem_wmask}, 64'hF0);
        check("sw_wdata", dmem_wdata, 64'h11223344_00000000);
        check("sw_addr", dmem_addr, 64'h3000);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("sw_wb_valid", {63'd0, wb_valid}, 64'd1);
        check("sw_wb_wena", {63'd0, wb_rd_wena}, 64'd0);

        // Misaligned word load.
        drive_op(64'h4002, 64'd0, 5'd11, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
        tick();
        idle_ex();
        check("mis_noreq", {63'd0, dmem_req}, 64'd0);
        check("mis_err", {63'd0, misalign_err}, 64'd1);
        check("mis_wb_valid", {63'd0, wb_valid}, 64'd1);
        check("mis_wena", {63'd0, wb_rd_wena}, 64'd0);
        check("mis_ready", {63'd0, ex_ready}, 64'd1);
        tick();
        check("mis_err_pulse", {63'd0, misalign_err}, 64'd0);

        // Reset while waiting for the ack, then a stray ack.
        drive_op(64'h5000, 64'd0, 5'd12, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0);
        tick();
        idle_ex();
        check("rsta_req", {63'd0, dmem_req}, 64'd1);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rsta_req_low", {63'd0, dmem_req}, 64'd0);
        check("rsta_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("rsta_ready", {63'd0, ex_ready}, 64'd1);
        dmem_ack = 1'b1; dmem_rdata = 64'h12345678_9ABCDEF0;
        tick();
        dmem_ack = 1'b0;
        check("stray_ack_wb", {63'd0, wb_valid}, 64'd0);
        check("stray_ack_req", {63'd0, dmem_req}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage directly downstream of the execute stage. It takes the execute result (ALU output or effective address) and either passes it to write-back after one register stage, or performs a single load/store on the data-memory bus. The memory access uses a req/ack handshake and stalls execute until the access completes. Load data is byte-lane extracted and sign/zero extended; store data is lane-aligned with a byte mask. Results are registered toward write-back.

## Interface
Parameters:
- XLEN, 64, register/data width; must equal the `REG_BUS` width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low; rst==0 at a rising edge resets the block.
- ex_valid  in  1  execute result present this cycle.
- ex_ready  out  1  stage can accept; combinational, =1 iff state IDLE.
- ex_rd_data  in  XLEN  ALU result / effective address.
- ex_store_data  in  XLEN  rs2 value for stores.
- ex_rd_addr  in  5  destination register.
- ex_rd_wena  in  1  destination write enable.
- ex_mem_ren  in  1  load.
- ex_mem_wen  in  1  store.
- ex_mem_size  in  2  0 byte, 1 half, 2 word, 3 dword.
- ex_mem_unsigned  in  1  zero-extend load.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 store, 0 load.
- dmem_addr  out  XLEN  ex_rd_data with [2:0] forced to 0.
- dmem_wdata  out  XLEN  lane-aligned store data.
- dmem_wmask  out  8  byte enables; 0 for loads.
- dmem_ack  in  1  access complete; rdata valid this cycle.
- dmem_rdata  in  XLEN  aligned 8-byte load data.
- wb_valid  out  1  write-back entry valid (one-cycle pulse per instruction).
- wb_rd_addr  out  5  destination register.
- wb_rd_wena  out  1  register write enable.
- wb_rd_data  out  XLEN  result.
- misalign_err  out  1  pulses with wb_valid for a misaligned access.

## Operation
- FSM states: IDLE, ACCESS.
- IDLE, ex_valid, no mem op: register ex_rd_data, rd_addr, rd_wena to wb_*; wb_valid=1 next cycle; stay IDLE. Throughput is 1 per cycle.
- IDLE, ex_valid, mem op, aligned: latch address, data, size, unsigned, rd; go to ACCESS.
- Alignment rule: addr[0]==0 for half; addr[1:0]==0 for word; addr[2:0]==0 for dword.
- IDLE, mem op misaligned: no bus request. Next cycle wb_valid=1, wb_rd_wena=0, misalign_err=1.
- ACCESS: dmem_req=1. All dmem_* outputs are registered and held stable until dmem_ack.
  - On ack: format the data, set wb_valid=1 next cycle, return to IDLE.
  - Store writeback: wb_rd_wena=0.
- ex_mem_ren and ex_mem_wen both 1: treated as a load.
- Store alignment: wdata = store_data << (8*addr[2:0]); wmask = ((1<<(1<<size))-1) << addr[2:0].
- Load extraction: shifted = rdata >> (8*addr[2:0]), then take the low 8/16/32/64 bits.
  - Sign-extend unless ex_mem_unsigned is set.
  - Dword loads ignore unsigned.
- dmem_ack outside ACCESS: ignored.
- No back-pressure from write-back.

## Timing
- Reset values: all outputs 0 (dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask, wb_*, misalign_err); state IDLE; ex_ready=1 after reset.
- Non-memory op accepted at cycle N: wb_valid at N+1.
- Memory op accepted at N:
  - dmem_req rises at N+1.
  - Ack at cycle M≥N+1 (same-cycle ack at N+1 is legal); wb_valid at M+1, dmem_req low at M+1.
  - ex_ready=0 from N+1 through M inclusive; high at M+1.
  - Minimum load-use latency: 2 cycles.
- ex_valid while ex_ready=0: ignored. Execute must hold its outputs.
- wb_valid and misalign_err are single-cycle pulses unless a new op is accepted the following cycle.
- Reset during ACCESS: the access is abandoned, dmem_req=0 next edge, and no wb_valid is produced. The bus must tolerate a dropped request.

## Structure
- Add to defines.v: MEM_SIZE_B/H/W/D codes, state encodings, `DMEM_MASK_BUS`.
- One combinational sub-module, mem_stage_align:
  - store lane shift and mask;
  - load extract and extend;
  - misalign detection.
- The FSM and registers stay in mem_stage.

## Test plan
- Non-memory stream: ex_valid on 3 consecutive cycles, rd_data 0x1,0x2,0x3, rd 5 → wb_valid for 3 consecutive cycles with data 0x1,0x2,0x3, rd_wena=1, no dmem_req.
- Signed byte load, addr 0x1003, rdata 0x00000000_80000000, ack 2 cycles after req:
  - dmem_addr 0x1000, wmask 0;
  - wb_rd_data 0xFFFFFFFF_FFFFFF80;
  - ex_ready low for 3 cycles.
- Unsigned half load, addr 0x2006, rdata 0xBEEF0000_00000000, same-cycle ack → wb_rd_data 0x000000000000BEEF at req+1.
- Word store, addr 0x3004, store_data 0x11223344 → dmem_we=1, wmask 0xF0, wdata 0x11223344_00000000, wb_rd_wena=0.
- Misaligned word load, addr 0x4002 → no dmem_req, misalign_err=1 and wb_valid=1 next cycle, wb_rd_wena=0.
- Reset (rst=0) asserted while waiting for ack → next cycle dmem_req=0, wb_valid=0, ex_ready=1; a later ack is ignored.
